// File: rtl/ad5676_pkg.sv
// Shared constants, FSM state type and code arithmetic for the AD5676
// front-panel controller.
package ad5676_pkg;

  localparam logic [3:0] CMD_WR_UPD = 4'b0011;
  localparam int         NUM_CH     = 8;
  localparam int         CH_W       = 3;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BCAST = 2'd2
  } state_e;

  // 17-bit add/subtract so the carry/borrow is visible before truncation.
  function automatic logic [15:0] step_code(input logic [15:0] code,
                                            input logic [15:0] step,
                                            input logic        up);
    logic [16:0] res;
    if (up) begin
      res = {1'b0, code} + {1'b0, step};
      return res[16] ? 16'hFFFF : res[15:0];
    end
    res = {1'b0, code} - {1'b0, step};
    return res[16] ? 16'h0000 : res[15:0];
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Press detector with hold-to-repeat for one debounced active-low key.
// evt_o pulses on the press and then on every auto-repeat tick.
module key_repeat #(
  parameter logic [24:0] REPEAT_DLY = 25'd25_000_000,
  parameter logic [24:0] REPEAT_PER = 25'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic evt_o
);

  logic        key_q;
  logic [24:0] cnt_q, cnt_d;
  logic        rpt_q, rpt_d;
  logic        press, held, hit;

  assign press = key_q & ~key_i;
  assign held  = ~key_q & ~key_i;

  // cnt_q holds the number of cycles since the press (or since the last repeat).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    rpt_d = rpt_q;
    hit   = held && (rpt_q ? (cnt_q == REPEAT_PER) : (cnt_q == REPEAT_DLY));
    if (key_i) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (press) begin
      cnt_d = 25'd1;
      rpt_d = 1'b0;
    end else if (hit) begin
      cnt_d = 25'd1;
      rpt_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 25'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= 1'b1;
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      key_q <= key_i;
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end

  assign evt_o = press | hit;

endmodule

// File: rtl/key_dac_ctrl.sv
// Front-panel key handling for the AD5676: per-channel code registers and a
// req/ack sequencer for single writes and 8-channel broadcasts.
module key_dac_ctrl
  import ad5676_pkg::*;
#(
  parameter logic [15:0] STEP       = 16'd256,
  parameter logic [24:0] REPEAT_DLY = 25'd25_000_000,
  parameter logic [24:0] REPEAT_PER = 25'd5_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_ch,
  input  logic        key_up,
  input  logic        key_dn,
  input  logic        key_load,
  input  logic        dac_ack,
  output logic        dac_req,
  output logic [3:0]  dac_cmd,
  output logic [3:0]  dac_addr,
  output logic [15:0] dac_data,
  output logic [2:0]  cur_ch,
  output logic        busy
);

  state_e            state_q, state_d;
  logic [15:0]       code_q [NUM_CH];
  logic [15:0]       code_d [NUM_CH];
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   bcnt_q, bcnt_d;
  logic              pending_q, pending_d;
  logic              pending_set, pending_clr;
  logic              req_q, req_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [3:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              key_ch_q, key_load_q;
  logic              ch_evt, load_evt, up_evt, dn_evt;

  key_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_rep_up (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .key_i (key_up),
    .evt_o (up_evt)
  );

  key_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_rep_dn (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .key_i (key_dn),
    .evt_o (dn_evt)
  );

  assign ch_evt   = key_ch_q & ~key_ch;
  assign load_evt = key_load_q & ~key_load;

  // Code edits are frozen during a broadcast; simultaneous up+down cancels.
  always_comb begin
    code_d      = code_q;
    pending_set = 1'b0;
    cur_ch_d    = ch_evt ? cur_ch_q + 3'd1 : cur_ch_q;
    if ((state_q != BCAST) && (up_evt ^ dn_evt)) begin
      code_d[cur_ch_q] = step_code(code_q[cur_ch_q], STEP, up_evt);
      pending_set      = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bcnt_d      = bcnt_q;
    pending_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_evt) begin
          bcnt_d  = '0;
          req_d   = 1'b1;
          cmd_d   = CMD_WR_UPD;
          addr_d  = 4'd0;
          data_d  = code_q[0];
          state_d = BCAST;
        end else if (pending_q) begin
          req_d       = 1'b1;
          cmd_d       = CMD_WR_UPD;
          addr_d      = {1'b0, cur_ch_q};
          data_d      = code_q[cur_ch_q];
          pending_clr = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (dac_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      BCAST: begin
        // req low for one cycle between channels; that cycle loads the next one.
        if (req_q) begin
          if (dac_ack) begin
            req_d = 1'b0;
            if (bcnt_q == LAST_CH) begin
              state_d = IDLE;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end else begin
          req_d  = 1'b1;
          addr_d = {1'b0, bcnt_q};
          data_d = code_q[bcnt_q];
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign pending_d = (pending_q & ~pending_clr) | pending_set;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cur_ch_q   <= '0;
      bcnt_q     <= '0;
      pending_q  <= 1'b0;
      req_q      <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      key_ch_q   <= 1'b1;
      key_load_q <= 1'b1;
      // NOTE: the code array is reset explicitly; it is a small flop bank, not a RAM macro.
      for (int i = 0; i < NUM_CH; i++) begin
        code_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      bcnt_q     <= bcnt_d;
      pending_q  <= pending_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      key_ch_q   <= key_ch;
      key_load_q <= key_load;
      for (int i = 0; i < NUM_CH; i++) begin
        code_q[i] <= code_d[i];
      end
    end
  end

  assign dac_req  = req_q;
  assign dac_cmd  = cmd_q;
  assign dac_addr = addr_q;
  assign dac_data = data_q;
  assign cur_ch   = cur_ch_q;
  assign busy     = (state_q != IDLE);

endmodule
